// File: rtl/ctrl_pipe_exc.sv
// ctrl_pipe_exc: control-bundle pipeline (ID/EX -> EX/MEM -> MEM/WB) with
// stall bubbles, branch flush and drain-then-request exception handling.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid, id_ctrl_exe/mem/wb, id_exception, id_pc   decoder bundle in ID
//   stall                      insert bubble into ID/EX
//   alu_zero                   ALU zero of instruction in EX/MEM
//   exc_ack                    handler accepts exception request
//   ex_reg_dst, ex_alu_src, ex_alu_op       ID/EX control
//   mem_read, mem_write, branch_flush       EX/MEM control
//   wb_reg_write, wb_mem2reg                MEM/WB control
//   if_hold, exc_req, epc                   exception interface
module ctrl_pipe_exc #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [3:0]      id_ctrl_exe,
  input  logic [2:0]      id_ctrl_mem,
  input  logic [1:0]      id_ctrl_wb,
  input  logic            id_exception,
  input  logic [PC_W-1:0] id_pc,
  input  logic            stall,
  input  logic            alu_zero,
  input  logic            exc_ack,
  output logic            ex_reg_dst,
  output logic            ex_alu_src,
  output logic [1:0]      ex_alu_op,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch_flush,
  output logic            wb_reg_write,
  output logic            wb_mem2reg,
  output logic            if_hold,
  output logic            exc_req,
  output logic [PC_W-1:0] epc
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REQ   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0] epc_q, epc_d;

  logic       idex_v_q, idex_v_d;
  logic [3:0] idex_exe_q, idex_exe_d;
  logic [2:0] idex_mem_q, idex_mem_d;
  logic [1:0] idex_wb_q, idex_wb_d;

  logic       exmem_v_q, exmem_v_d;
  logic [2:0] exmem_mem_q, exmem_mem_d;
  logic [1:0] exmem_wb_q, exmem_wb_d;

  logic       memwb_v_q;
  logic [1:0] memwb_wb_q;

  logic flush;

  assign flush = exmem_v_q & exmem_mem_q[2] & alu_zero;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    epc_d      = epc_q;
    idex_v_d   = 1'b0;
    idex_exe_d = '0;
    idex_mem_d = '0;
    idex_wb_d  = '0;

    // ID/EX load priority: flush, busy FSM, exception capture, stall, load.
    if (flush) begin
      idex_v_d = 1'b0;
    end else if (state_q != IDLE) begin
      idex_v_d = 1'b0;
    end else if (id_valid && id_exception) begin
      epc_d   = id_pc;
      state_d = DRAIN;
      cnt_d   = CW'(DRAIN_CYCLES - 1);
    end else if (stall) begin
      idex_v_d = 1'b0;
    end else begin
      idex_v_d   = id_valid;
      idex_exe_d = id_ctrl_exe;
      idex_mem_d = id_ctrl_mem;
      idex_wb_d  = id_ctrl_wb;
    end

    case (state_q)
      DRAIN: begin
        // A flush here means the faulting instruction was on the wrong path.
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = REQ;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      REQ: begin
        if (exc_ack) state_d = IDLE;
      end
      default: ;
    endcase

    if (flush) begin
      exmem_v_d   = 1'b0;
      exmem_mem_d = '0;
      exmem_wb_d  = '0;
    end else begin
      exmem_v_d   = idex_v_q;
      exmem_mem_d = idex_mem_q;
      exmem_wb_d  = idex_wb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      epc_q       <= '0;
      idex_v_q    <= 1'b0;
      idex_exe_q  <= '0;
      idex_mem_q  <= '0;
      idex_wb_q   <= '0;
      exmem_v_q   <= 1'b0;
      exmem_mem_q <= '0;
      exmem_wb_q  <= '0;
      memwb_v_q   <= 1'b0;
      memwb_wb_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      epc_q       <= epc_d;
      idex_v_q    <= idex_v_d;
      idex_exe_q  <= idex_exe_d;
      idex_mem_q  <= idex_mem_d;
      idex_wb_q   <= idex_wb_d;
      exmem_v_q   <= exmem_v_d;
      exmem_mem_q <= exmem_mem_d;
      exmem_wb_q  <= exmem_wb_d;
      memwb_v_q   <= exmem_v_q;
      memwb_wb_q  <= exmem_wb_q;
    end
  end

  assign ex_reg_dst   = idex_exe_q[0];
  assign ex_alu_src   = idex_exe_q[1];
  assign ex_alu_op    = idex_exe_q[3:2];
  assign mem_read     = exmem_mem_q[0];
  assign mem_write    = exmem_mem_q[1];
  assign branch_flush = flush;
  assign wb_reg_write = memwb_wb_q[0];
  assign wb_mem2reg   = memwb_wb_q[1];
  assign if_hold      = (state_q != IDLE);
  assign exc_req      = (state_q == REQ);
  assign epc          = epc_q;

  logic unused_memwb_v;
  assign unused_memwb_v = memwb_v_q;

endmodule

// File: tb/tb_ctrl_pipe_exc.sv
// Directed testbench for ctrl_pipe_exc.
module tb_ctrl_pipe_exc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_ctrl_exe;
  logic [2:0]  id_ctrl_mem;
  logic [1:0]  id_ctrl_wb;
  logic        id_exception;
  logic [31:0] id_pc;
  logic        stall, alu_zero, exc_ack;
  logic        ex_reg_dst, ex_alu_src;
  logic [1:0]  ex_alu_op;
  logic        mem_read, mem_write, branch_flush;
  logic        wb_reg_write, wb_mem2reg;
  logic        if_hold, exc_req;
  logic [31:0] epc;

  int tests = 0;
  int fails = 0;

  ctrl_pipe_exc #(.PC_W(32), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ctrl_exe(id_ctrl_exe), .id_ctrl_mem(id_ctrl_mem),
    .id_ctrl_wb(id_ctrl_wb), .id_exception(id_exception), .id_pc(id_pc),
    .stall(stall), .alu_zero(alu_zero), .exc_ack(exc_ack),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .branch_flush(branch_flush),
    .wb_reg_write(wb_reg_write), .wb_mem2reg(wb_mem2reg),
    .if_hold(if_hold), .exc_req(exc_req), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] e, input logic [2:0] m,
                       input logic [1:0] w, input logic x, input logic [31:0] pc);
    id_valid = v; id_ctrl_exe = e; id_ctrl_mem = m; id_ctrl_wb = w;
    id_exception = x; id_pc = pc;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; alu_zero = 0; exc_ack = 0;
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step(); step();
    tests++;
    if ({ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write, branch_flush,
         wb_reg_write, wb_mem2reg, if_hold, exc_req} !== 11'b0 || epc !== 32'h0) begin
      fails++; $display("FAIL reset_outputs: got ex=%b%b%b mem=%b%b wb=%b%b hold=%b req=%b epc=%h, want all 0",
        ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write, wb_reg_write, wb_mem2reg, if_hold, exc_req, epc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    drive(1, 4'b0010, 3'b001, 2'b01, 0, 32'h0);
    step();
    tests++;
    if (ex_alu_src !== 1'b1 || ex_alu_op !== 2'b00 || ex_reg_dst !== 1'b0) begin
      fails++; $display("FAIL lat_ex: alu_src=%b op=%b dst=%b, want 1 00 0", ex_alu_src, ex_alu_op, ex_reg_dst);
    end
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step();
    tests++;
    if (mem_read !== 1'b1 || ex_alu_src !== 1'b0) begin
      fails++; $display("FAIL lat_mem: mem_read=%b ex_alu_src=%b, want 1 0", mem_read, ex_alu_src);
    end
    step();
    tests++;
    if (wb_reg_write !== 1'b1 || mem_read !== 1'b0 || wb_mem2reg !== 1'b0) begin
      fails++; $display("FAIL lat_wb: reg_write=%b mem_read=%b mem2reg=%b, want 1 0 0", wb_reg_write, mem_read, wb_mem2reg);
    end
  endtask

  task automatic test_stall();
    drive(1, 4'b1001, 3'b000, 2'b01, 0, 32'h0);
    stall = 1;
    step();
    tests++;
    if ({ex_alu_op, ex_alu_src, ex_reg_dst} !== 4'b0000) begin
      fails++; $display("FAIL stall_bubble: ex=%b%b%b, want 0000", ex_alu_op, ex_alu_src, ex_reg_dst);
    end
    stall = 0;
    step();
    tests++;
    if (ex_alu_op !== 2'b10 || ex_reg_dst !== 1'b1 || ex_alu_src !== 1'b0) begin
      fails++; $display("FAIL stall_release: op=%b dst=%b src=%b, want 10 1 0", ex_alu_op, ex_reg_dst, ex_alu_src);
    end
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step(); step(); step();
  endtask

  task automatic test_branch_flush();
    drive(1, 4'b0100, 3'b100, 2'b00, 0, 32'h0);     // beq
    step();
    drive(1, 4'b0010, 3'b001, 2'b01, 0, 32'h0);     // lw behind it
    step();
    alu_zero = 1; #1;
    tests++;
    if (branch_flush !== 1'b1) begin
      fails++; $display("FAIL flush_assert: branch_flush=%b, want 1", branch_flush);
    end
    step();
    tests++;
    if (mem_read !== 1'b0 || ex_alu_src !== 1'b0 || branch_flush !== 1'b0) begin
      fails++; $display("FAIL flush_bubbles: mem_read=%b ex_alu_src=%b flush=%b, want 0 0 0", mem_read, ex_alu_src, branch_flush);
    end
    alu_zero = 0;
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step(); step(); step();
  endtask

  task automatic test_exception();
    drive(1, 4'b0010, 3'b001, 2'b01, 1, 32'h0040_0010);
    step();
    tests++;
    if (if_hold !== 1'b1 || exc_req !== 1'b0 || epc !== 32'h0040_0010 || ex_alu_src !== 1'b0) begin
      fails++; $display("FAIL exc_capture: hold=%b req=%b epc=%h src=%b, want 1 0 00400010 0", if_hold, exc_req, epc, ex_alu_src);
    end
    drive(1, 4'b0010, 3'b001, 2'b01, 0, 32'h0);     // held off while draining
    step();
    tests++;
    if (exc_req !== 1'b0 || if_hold !== 1'b1 || ex_alu_src !== 1'b0) begin
      fails++; $display("FAIL exc_drain: req=%b hold=%b src=%b, want 0 1 0", exc_req, if_hold, ex_alu_src);
    end
    step();
    tests++;
    if (exc_req !== 1'b1 || epc !== 32'h0040_0010) begin
      fails++; $display("FAIL exc_req_rise: req=%b epc=%h, want 1 00400010", exc_req, epc);
    end
    step();
    tests++;
    if (exc_req !== 1'b1 || ex_alu_src !== 1'b0) begin
      fails++; $display("FAIL exc_req_hold: req=%b src=%b, want 1 0", exc_req, ex_alu_src);
    end
    exc_ack = 1;
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step();
    tests++;
    if (exc_req !== 1'b0 || if_hold !== 1'b0 || epc !== 32'h0040_0010) begin
      fails++; $display("FAIL exc_ack: req=%b hold=%b epc=%h, want 0 0 00400010", exc_req, if_hold, epc);
    end
    step();                                         // ack held in IDLE is ignored
    tests++;
    if (exc_req !== 1'b0 || if_hold !== 1'b0) begin
      fails++; $display("FAIL ack_idle: req=%b hold=%b, want 0 0", exc_req, if_hold);
    end
    exc_ack = 0;
  endtask

  task automatic test_cancel();
    drive(1, 4'b0100, 3'b100, 2'b00, 0, 32'h0);     // beq
    step();
    drive(1, 4'b0000, 3'b000, 2'b00, 1, 32'h0040_0020);
    stall = 1;                                      // stall must not block capture
    step();
    stall = 0;
    tests++;
    if (if_hold !== 1'b1 || epc !== 32'h0040_0020) begin
      fails++; $display("FAIL cancel_capture: hold=%b epc=%h, want 1 00400020", if_hold, epc);
    end
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    alu_zero = 1;
    step();
    alu_zero = 0;
    tests++;
    if (if_hold !== 1'b0 || exc_req !== 1'b0 || epc !== 32'h0040_0020) begin
      fails++; $display("FAIL cancel_idle: hold=%b req=%b epc=%h, want 0 0 00400020", if_hold, exc_req, epc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (exc_req !== 1'b0 || if_hold !== 1'b0) begin
        fails++; $display("FAIL cancel_noreq[%0d]: req=%b hold=%b, want 0 0", i, exc_req, if_hold);
      end
    end
    // flush and exception in the same cycle
    drive(1, 4'b0100, 3'b100, 2'b00, 0, 32'h0);
    step();
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step();
    alu_zero = 1;
    drive(1, 4'b0000, 3'b000, 2'b00, 1, 32'h0040_0030);
    step();
    alu_zero = 0;
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    tests++;
    if (if_hold !== 1'b0 || epc !== 32'h0040_0020) begin
      fails++; $display("FAIL flush_beats_exc: hold=%b epc=%h, want 0 00400020", if_hold, epc);
    end
    step();
  endtask

  task automatic test_async_reset();
    drive(1, 4'h0, 3'h0, 2'h0, 1, 32'h0040_0040);
    step();
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    step(); step();
    tests++;
    if (exc_req !== 1'b1 || epc !== 32'h0040_0040) begin
      fails++; $display("FAIL pre_reset_req: req=%b epc=%h, want 1 00400040", exc_req, epc);
    end
    #2 rst_n = 1'b0; #1;
    tests++;
    if (exc_req !== 1'b0 || epc !== 32'h0 || if_hold !== 1'b0) begin
      fails++; $display("FAIL async_reset_req: req=%b epc=%h hold=%b, want 0 0 0", exc_req, epc, if_hold);
    end
    rst_n = 1'b1;
    drive(1, 4'b0010, 3'b001, 2'b01, 0, 32'h0);
    step();
    drive(0, 4'h0, 3'h0, 2'h0, 0, 32'h0);
    tests++;
    if (ex_alu_src !== 1'b1) begin
      fails++; $display("FAIL post_reset_load: ex_alu_src=%b, want 1", ex_alu_src);
    end
    #2 rst_n = 1'b0; #1;
    tests++;
    if (ex_alu_src !== 1'b0 || mem_read !== 1'b0 || wb_reg_write !== 1'b0) begin
      fails++; $display("FAIL async_reset_stage: src=%b mem_read=%b reg_write=%b, want 0 0 0", ex_alu_src, mem_read, wb_reg_write);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_branch_flush();
    test_exception();
    test_cancel();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
